// File: rtl/modulo_arbitro_mux4_pkg.sv
// Shared constants for the round-robin arbiter in front of the 4:1 bit mux.
package pkg_arbitro;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_GRANT   = 2'b01,
    S_RELEASE = 2'b10
  } state_t;

endpackage

// File: rtl/modulo_arbitro_mux4_mux.sv
// Single-bit 4:1 mux: i_data[0]=A, [1]=B, [2]=C, [3]=D.
module modulo_mux4_1 (
  input  logic [3:0] i_data,
  input  logic [1:0] i_sel,
  output logic       o_out
);

  always_comb begin
    case (i_sel)
      2'd0:    o_out = i_data[0];
      2'd1:    o_out = i_data[1];
      2'd2:    o_out = i_data[2];
      default: o_out = i_data[3];
    endcase
  end

endmodule

// File: rtl/modulo_arbitro_mux4.sv
// Round-robin arbiter driving the 4:1 mux select; grants are hold-limited
// and separated by one idle (RELEASE) cycle, and the mux bit is gated by valid.
module modulo_arbitro_mux4
  import pkg_arbitro::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] data,
  output logic [3:0] grant,
  output logic [1:0] input_sel,
  output logic       valid,
  output logic       out
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic             r_valid;

  state_t           w_state_nxt;
  logic [1:0]       w_owner_nxt;
  logic [1:0]       w_last_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [3:0]       w_grant_nxt;
  logic [1:0]       w_sel_nxt;
  logic             w_valid_nxt;
  logic [2:0]       w_pick;
  logic             w_mux;

  // Returns {found, index}; the search runs last+1, last+2, last+3, last.
  // Iterating from the lowest priority up lets the highest one overwrite.
  function automatic logic [2:0] f_rr_pick(input logic [3:0] rq, input logic [1:0] lst);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = lst + i[1:0];
      if (rq[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_pick = f_rr_pick(req, r_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner    <= 2'd0;
      r_last     <= 2'd3;
      r_hold_cnt <= '0;
      r_grant    <= 4'b0000;
      r_sel      <= 2'd0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE, S_RELEASE: begin
        if (w_pick[2]) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_pick[1:0];
          w_grant_nxt = 4'(4'b0001 << w_pick[1:0]);
          w_sel_nxt   = w_pick[1:0];
          w_valid_nxt = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          // input_sel deliberately keeps the previous owner while idle
          w_state_nxt = S_IDLE;
          w_grant_nxt = 4'b0000;
          w_valid_nxt = 1'b0;
        end
      end
      S_GRANT: begin
        if (!req[r_owner] || (r_hold_cnt == HOLD_LAST)) begin
          w_state_nxt = S_RELEASE;
          w_grant_nxt = 4'b0000;
          w_valid_nxt = 1'b0;
          w_last_nxt  = r_owner;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  modulo_mux4_1 u_mux (
    .i_data (data),
    .i_sel  (r_sel),
    .o_out  (w_mux)
  );

  always_comb begin
    grant     = r_grant;
    input_sel = r_sel;
    valid     = r_valid;
    out       = r_valid & w_mux;
  end

endmodule

// File: tb/tb_modulo_arbitro_mux4.sv
// Directed bench for modulo_arbitro_mux4 with MAX_HOLD left at 8.
module tb_modulo_arbitro_mux4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] grant;
  logic [1:0] input_sel;
  logic       valid;
  logic       out;

  int n_checks = 0;
  int n_pass   = 0;

  modulo_arbitro_mux4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .input_sel (input_sel),
    .valid     (valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Checks n cycles of grant g starting at the current cycle, then the RELEASE cycle.
  task automatic expect_grant(input string tag, input logic [3:0] g, input int n);
    for (int c = 0; c < n; c++) begin
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_sel"},   32'(input_sel), 32'(idx_of(g)));
      chk({tag, "_out"},   32'(out), 32'(|(g & data)));
      tick();
    end
    chk({tag, "_rel_grant"}, 32'(grant), 32'd0);
    chk({tag, "_rel_valid"}, 32'(valid), 32'd0);
    chk({tag, "_rel_out"},   32'(out), 32'd0);
  endtask

  logic [3:0] seq [5];

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;
    reset = 1'b1;
    req   = 4'b0000;
    data  = 4'b0000;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel",   32'(input_sel), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_out",   32'(out), 32'd0);
    reset = 1'b0;

    // single request from requester 2
    req  = 4'b0100;
    data = 4'b0100;
    tick();
    chk("single_grant", 32'(grant), 32'b0100);
    chk("single_sel",   32'(input_sel), 32'd2);
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_out",   32'(out), 32'd1);
    req = 4'b0000;
    tick();
    chk("drop_grant", 32'(grant), 32'd0);
    chk("drop_valid", 32'(valid), 32'd0);
    chk("drop_sel",   32'(input_sel), 32'd2);
    chk("drop_out",   32'(out), 32'd0);
    data = 4'b1111;
    #1;
    chk("gate_release_out", 32'(out), 32'd0);
    tick();
    chk("idle_valid", 32'(valid), 32'd0);
    chk("idle_sel",   32'(input_sel), 32'd2);
    chk("gate_idle_out", 32'(out), 32'd0);

    // asynchronous reset in the middle of a grant to requester 2
    data = 4'b0100;
    req  = 4'b0100;
    tick();
    chk("pre_arst_grant", 32'(grant), 32'b0100);
    chk("pre_arst_out",   32'(out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_sel",   32'(input_sel), 32'd0);
    chk("arst_out",   32'(out), 32'd0);
    req  = 4'b1111;
    data = 4'b1010;
    tick();
    reset = 1'b0;
    tick();

    // all requesting: rotation 0,1,2,3,0 with 8-cycle grants
    for (int g = 0; g < 5; g++) begin
      expect_grant($sformatf("all%0d", g), seq[g], 8);
      tick();
    end
    chk("all_wrap_grant", 32'(grant), 32'b0010);
    req = 4'b0000;
    tick();
    tick();
    chk("all_end_valid", 32'(valid), 32'd0);

    // sole requester 1 gets re-granted after each hold limit
    req  = 4'b0010;
    data = 4'b0010;
    tick();
    expect_grant("sole_a", 4'b0010, 8);
    tick();
    expect_grant("sole_b", 4'b0010, 8);

    // owner drops its request in the very cycle the hold limit is reached
    req = 4'b0110;
    tick();
    for (int c = 0; c < 8; c++) begin
      chk("simul_grant", 32'(grant), 32'b0100);
      chk("simul_valid", 32'(valid), 32'd1);
      if (c == 7) req = 4'b0001;
      tick();
    end
    chk("simul_rel_grant", 32'(grant), 32'd0);
    chk("simul_rel_valid", 32'(valid), 32'd0);
    req = 4'b0101;
    tick();
    chk("simul_next_grant", 32'(grant), 32'b0001);
    chk("simul_next_valid", 32'(valid), 32'd1);

    req = 4'b0000;
    tick();
    tick();
    chk("final_valid", 32'(valid), 32'd0);
    chk("final_grant", 32'(grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
